toy_phy_reg_release_queue: RTL and testbench

//  Buffers physical-register release requests from the commit stage.

---
 rtl/toy_phy_reg_release_queue_if.sv | 11 +
 rtl/toy_phy_reg_release_queue.sv | 80 ++++++++
 tb/tb_toy_phy_reg_release_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/toy_phy_reg_release_queue_if.sv
// toy_phy_reg_release_queue_if: commit-side release request handshake
interface toy_phy_reg_release_queue_if #(
  parameter int COMMIT_NUM       = 4,
  parameter int PHY_REG_ID_WIDTH = 7
);
  logic [COMMIT_NUM-1:0]                       v_rel_vld;
  logic [COMMIT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_rel_id;
  logic                                        rel_rdy;
  modport master (output v_rel_vld, output v_rel_id, input rel_rdy);
  modport slave (input v_rel_vld, input v_rel_id, output rel_rdy);
endinterface

// File: rtl/toy_phy_reg_release_queue.sv
// toy_phy_reg_release_queue: buffers commit-stage phy-reg releases, drains them as a one-cycle bitmap
module toy_phy_reg_release_queue #(
  parameter int MODE             = 0,
  parameter int PHY_REG_NUM      = 128,
  parameter int PHY_REG_ID_WIDTH = 7,
  parameter int COMMIT_NUM       = 4,
  parameter int DRAIN_NUM        = 2,
  parameter int DEPTH            = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  toy_phy_reg_release_queue_if.slave   rel,
  input  logic                         drain_en,
  output logic [PHY_REG_NUM-1:0]       v_reg_phy_release,
  output logic [$clog2(DEPTH):0]       fifo_cnt,
  output logic                         dup_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PHY_REG_ID_WIDTH-1:0] mem_q [DEPTH];
  logic [PHY_REG_ID_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PHY_REG_NUM-1:0]      rel_q, rel_d;
  logic                        dup_q, dup_d;
  logic [PW-1:0]               cnt, n, off, wa, ra;
  logic [PHY_REG_ID_WIDTH-1:0] rid;
  logic                        accept, dup;
  assign cnt               = wr_ptr_q - rd_ptr_q;
  assign rel.rel_rdy       = 32'(cnt) <= DEPTH - COMMIT_NUM;
  assign accept            = rel.rel_rdy && |rel.v_rel_vld;
  assign n                 = !drain_en ? '0 : (32'(cnt) < DRAIN_NUM ? cnt : PW'(DRAIN_NUM));
  assign v_reg_phy_release = rel_q;
  assign fifo_cnt          = cnt;
  assign dup_err           = dup_q;
  // Kept lanes are packed densely starting at wr_ptr; id 0 is never stored for the INT file
  always_comb begin
    mem_d = mem_q;
    off   = '0;
    wa    = wr_ptr_q;
    for (int i = 0; i < COMMIT_NUM; i++) begin
      if (accept && rel.v_rel_vld[i] && (MODE != 0 || rel.v_rel_id[i] != '0)) begin
        wa = wr_ptr_q + off;
        mem_d[wa[AW-1:0]] = rel.v_rel_id[i];
        off = off + PW'(1);
      end
    end
    wr_ptr_d = wr_ptr_q + off;
  end
  always_comb begin
    rel_d = '0;
    dup   = 1'b0;
    ra    = rd_ptr_q;
    rid   = '0;
    for (int j = 0; j < DRAIN_NUM; j++) begin
      ra  = rd_ptr_q + PW'(j);
      rid = mem_q[ra[AW-1:0]];
      if (PW'(j) < n) begin
        dup = dup | rel_d[rid];
        rel_d[rid] = 1'b1;
      end
    end
    rd_ptr_d = rd_ptr_q + n;
    dup_d    = dup_q | dup;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rel_q    <= '0;
      dup_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rel_q    <= rel_d;
      dup_q    <= dup_d;
    end
  end
endmodule

// File: tb/tb_toy_phy_reg_release_queue.sv
// tb_toy_phy_reg_release_queue: directed checks of the release queue, INT and FP instances side by side
module tb_toy_phy_reg_release_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain_en = 1'b0;
  logic [127:0] rel0, rel1;
  logic [4:0] cnt0, cnt1;
  logic dup0, dup1;
  int total = 0;
  int bad = 0;
  toy_phy_reg_release_queue_if #(.COMMIT_NUM(4), .PHY_REG_ID_WIDTH(7)) if0 ();
  toy_phy_reg_release_queue_if #(.COMMIT_NUM(4), .PHY_REG_ID_WIDTH(7)) if1 ();
  toy_phy_reg_release_queue #(.MODE(0)) dut0 (.clk(clk), .rst(rst), .rel(if0.slave), .drain_en(drain_en),
    .v_reg_phy_release(rel0), .fifo_cnt(cnt0), .dup_err(dup0));
  toy_phy_reg_release_queue #(.MODE(1)) dut1 (.clk(clk), .rst(rst), .rel(if1.slave), .drain_en(drain_en),
    .v_reg_phy_release(rel1), .fifo_cnt(cnt1), .dup_err(dup1));
  always #5 clk = ~clk;
  function automatic logic [127:0] b(input int id);
    return 128'(1) << id;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] vld, input int a, input int b_, input int c, input int d);
    if0.v_rel_vld = vld;
    if1.v_rel_vld = vld;
    if0.v_rel_id  = {7'(d), 7'(c), 7'(b_), 7'(a)};
    if1.v_rel_id  = {7'(d), 7'(c), 7'(b_), 7'(a)};
  endtask
  initial begin
    drive(4'b0000, 0, 0, 0, 0);
    step();
    chk("rst_cnt", 128'(cnt0), 0);
    chk("rst_bitmap", rel0, 0);
    chk("rst_dup", 128'(dup0), 0);
    chk("rst_rdy", 128'(if0.rel_rdy), 1);
    rst = 1'b0;
    // basic enqueue then two-per-cycle drain
    drive(4'b1111, 5, 6, 7, 8);
    drain_en = 1'b1;
    step();
    drive(4'b0000, 0, 0, 0, 0);
    chk("t1_cnt4", 128'(cnt0), 4);
    chk("t1_noearly", rel0, 0);
    step();
    chk("t1_bm56", rel0, b(5) | b(6));
    chk("t1_cnt2", 128'(cnt0), 2);
    step();
    chk("t1_bm78", rel0, b(7) | b(8));
    chk("t1_cnt0", 128'(cnt0), 0);
    step();
    chk("t1_bm0", rel0, 0);
    // id 0 dropped only for the INT instance
    drain_en = 1'b0;
    drive(4'b1011, 0, 9, 33, 12);
    step();
    drive(4'b0000, 0, 0, 0, 0);
    chk("t2_int_cnt", 128'(cnt0), 2);
    chk("t2_fp_cnt", 128'(cnt1), 3);
    drain_en = 1'b1;
    step();
    chk("t2_int_bm", rel0, b(9) | b(12));
    chk("t2_fp_bm", rel1, b(0) | b(9));
    step();
    chk("t2_int_bm2", rel0, 0);
    chk("t2_fp_bm2", rel1, b(12));
    chk("t2_fp_cnt0", 128'(cnt1), 0);
    // fill to 16, then drain and watch rel_rdy recover at 12
    drain_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      drive(4'b1111, 40 + 4 * g, 41 + 4 * g, 42 + 4 * g, 43 + 4 * g);
      step();
    end
    drive(4'b0000, 0, 0, 0, 0);
    chk("t3_full_cnt", 128'(cnt0), 16);
    chk("t3_full_rdy", 128'(if0.rel_rdy), 0);
    drain_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t3_bm%0d", k), rel0, b(40 + 2 * k) | b(41 + 2 * k));
      chk($sformatf("t3_cnt%0d", k), 128'(cnt0), 128'(14 - 2 * k));
      chk($sformatf("t3_rdy%0d", k), 128'(if0.rel_rdy), (14 - 2 * k) <= 12 ? 1 : 0);
    end
    step();
    chk("t3_idle", rel0, 0);
    // wrap: fresh pointers, prefill 14, drain, push across slot 15 -> 0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drain_en = 1'b0;
    for (int g = 0; g < 3; g++) begin
      drive(4'b1111, 60 + 4 * g, 61 + 4 * g, 62 + 4 * g, 63 + 4 * g);
      step();
    end
    drive(4'b0011, 72, 73, 0, 0);
    step();
    drive(4'b0000, 0, 0, 0, 0);
    chk("t4_pre_cnt", 128'(cnt0), 14);
    drain_en = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("t4_last_pre", rel0, b(72) | b(73));
    chk("t4_empty", 128'(cnt0), 0);
    drive(4'b1111, 20, 21, 22, 23);
    step();
    drive(4'b0000, 0, 0, 0, 0);
    chk("t4_wr_cnt", 128'(cnt0), 4);
    step();
    chk("t4_bm2021", rel0, b(20) | b(21));
    step();
    chk("t4_bm2223", rel0, b(22) | b(23));
    step();
    chk("t4_empty_drain", rel0, 0);
    chk("t4_cnt0", 128'(cnt0), 0);
    // duplicate ids within one drain
    drain_en = 1'b0;
    drive(4'b0011, 30, 30, 0, 0);
    step();
    drive(4'b0000, 0, 0, 0, 0);
    chk("t5_nodup_yet", 128'(dup0), 0);
    drain_en = 1'b1;
    step();
    chk("t5_bm30", rel0, b(30));
    chk("t5_dup", 128'(dup0), 1);
    step();
    step();
    chk("t5_dup_sticky", 128'(dup0), 1);
    chk("t5_bm0", rel0, 0);
    // async reset mid-operation with 10 queued
    drain_en = 1'b0;
    drive(4'b1111, 80, 81, 82, 83);
    step();
    drive(4'b1111, 84, 85, 86, 87);
    step();
    drive(4'b0011, 88, 89, 0, 0);
    step();
    drive(4'b0000, 0, 0, 0, 0);
    chk("t6_cnt10", 128'(cnt0), 10);
    drain_en = 1'b1;
    step();
    chk("t6_bm8081", rel0, b(80) | b(81));
    rst = 1'b1;
    #1;
    chk("t6_rst_cnt", 128'(cnt0), 0);
    chk("t6_rst_bm", rel0, 0);
    chk("t6_rst_dup", 128'(dup0), 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_quiet%0d", k), rel0, 0);
      chk($sformatf("t6_quiet_cnt%0d", k), 128'(cnt0), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
